// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_INC   = 3'd1,
        SEL_REDIR = 3'd2,
        SEL_TRAP  = 3'd3,
        SEL_MRET  = 3'd4
    } pc_sel_t;

    // Low address bits that must be zero for a legal 32-bit instruction fetch.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_next_sel.sv
// Priority encoder for the next-PC source: trap > mret > redirect > increment > hold.
module pc_next_sel
    import pc_pkg::*;
(
    input  logic       evt_en,
    input  logic       inc_en,
    input  logic       trap_valid,
    input  logic       mret_valid,
    input  logic       redirect_valid,
    input  logic [1:0] redirect_lsb,
    input  logic       fetch_ready,
    output pc_sel_t    sel,
    output logic       redir_mis
);

    always_comb begin
        sel       = SEL_HOLD;
        redir_mis = 1'b0;
        if (evt_en) begin
            if (trap_valid) begin
                sel = SEL_TRAP;
            end else if (mret_valid) begin
                sel = SEL_MRET;
            end else if (redirect_valid) begin
                sel       = SEL_REDIR;
                redir_mis = |(redirect_lsb & ALIGN_MASK);
            end else if (inc_en && fetch_ready) begin
                sel = SEL_INC;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// RV32I program-counter unit: prioritised next-PC selection, fetch handshake,
// halt/resume and exception-PC capture.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              PC_INC       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            halt_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] epc,
    output logic            misaligned,
    output logic            halted
);

    pc_state_t       state, state_nx;
    pc_sel_t         sel;
    logic            redir_mis;
    logic            evt_en, inc_en;
    logic [XLEN-1:0] pc_nx, epc_nx;

    assign pc_plus_inc = pc + XLEN'(PC_INC);
    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);

    always_comb begin
        state_nx = state;
        evt_en   = 1'b0;
        inc_en   = 1'b0;
        case (state)
            BOOT: state_nx = halt_req ? HALT : RUN;
            RUN: begin
                evt_en   = 1'b1;
                inc_en   = 1'b1;
                state_nx = halt_req ? HALT : RUN;
            end
            HALT: begin
                // Control flow changes still land while halted; only increment stops.
                evt_en   = 1'b1;
                state_nx = halt_req ? HALT : RUN;
            end
            default: state_nx = BOOT;
        endcase
    end

    pc_next_sel u_sel (
        .evt_en         (evt_en),
        .inc_en         (inc_en),
        .trap_valid     (trap_valid),
        .mret_valid     (mret_valid),
        .redirect_valid (redirect_valid),
        .redirect_lsb   (redirect_target[1:0]),
        .fetch_ready    (fetch_ready),
        .sel            (sel),
        .redir_mis      (redir_mis)
    );

    always_comb begin
        pc_nx  = pc;
        epc_nx = epc;
        case (sel)
            SEL_TRAP: begin
                pc_nx  = TRAP_VECTOR;
                epc_nx = trap_pc;
            end
            SEL_MRET: pc_nx = epc;
            SEL_REDIR: begin
                if (redir_mis) begin
                    pc_nx  = TRAP_VECTOR;
                    epc_nx = redirect_target;
                end else begin
                    pc_nx = redirect_target;
                end
            end
            SEL_INC: pc_nx = pc_plus_inc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            epc        <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            epc        <= epc_nx;
            misaligned <= redir_mis;
        end
    end

endmodule
